serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/sub_pkg.sv | 15 +
 rtl/full_subtractor.sv | 15 +
 rtl/serial_subtractor.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: controller states and
// the default operand width.
package sub_pkg;

    // Controller states of the serial subtractor.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Default operand/result width.
    localparam int DEFAULT_WIDTH = 4;

endpackage : sub_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit is the parity of the three inputs; a borrow leaves the
    // cell when a is 0 and b is 1, or when a equals b and a borrow came in.
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes x - y - bin one bit per clock, LSB first,
// and presents the difference and borrow-out with a one-cycle done pulse.
// Optional feature: define SERIAL_SUB_OVF_EN to add the two's-complement
// overflow output ovf.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    // Bit counter only needs to reach WIDTH-1.
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_q;    // all WIDTH bits have been processed
    logic [WIDTH-1:0] x_q;       // minuend, shifted right one bit per step
    logic [WIDTH-1:0] y_q;       // subtrahend, shifted right one bit per step
    logic [WIDTH-1:0] acc_q;     // difference assembled MSB-in
    logic             b_q;       // running borrow between bit steps
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
`ifdef SERIAL_SUB_OVF_EN
    logic             xmsb_q;    // operand sign bits, kept for the overflow rule
    logic             ymsb_q;
    logic             ovf_q;
`endif

    logic bit_diff;
    logic bit_borrow;

    full_subtractor u_cell (
        .a    (x_q[0]),
        .b    (y_q[0]),
        .bin  (b_q),
        .d    (bit_diff),
        .bout (bit_borrow)
    );

    // Controller and datapath: capture on accepted start, one bit per SHIFT
    // edge, then one closing SHIFT edge commits the assembled result to the
    // output registers as the machine enters DONE.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses non-blocking assignment so all state
        // updates see the values from before the edge, regardless of order.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            xmsb_q  <= 1'b0;
            ymsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q     <= x;
                        y_q     <= y;
                        b_q     <= bin;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        xmsb_q  <= x[WIDTH-1];
                        ymsb_q  <= y[WIDTH-1];
`endif
                        state_q <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (!last_q) begin
                        x_q   <= {1'b0, x_q[WIDTH-1:1]};
                        y_q   <= {1'b0, y_q[WIDTH-1:1]};
                        acc_q <= {bit_diff, acc_q[WIDTH-1:1]};
                        b_q   <= bit_borrow;
                        // Counter saturates at the final bit instead of wrapping.
                        if (cnt_q == CNT_MAX) begin
                            last_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end else begin
                        d_q     <= acc_q;
                        bout_q  <= b_q;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q   <= (xmsb_q != ymsb_q) && (acc_q[WIDTH-1] != xmsb_q);
`endif
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    // start is deliberately ignored here; the result stays held.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule : serial_subtractor
